// File: rtl/ftsd_scan_sched.sv
// Digit scan scheduler: prescaled 0..3 digit index, per-period blanking, frame-aligned shadow load.
// Registered outputs, one cycle behind the scan state; upd_req is a level held until the upd_ack pulse.
module ftsd_scan_sched #(
    parameter int DIV_W     = 16,
    parameter int BLANK_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in0,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    input  logic [3:0] digit_en,
    input  logic       upd_req,
    output logic       upd_ack,
    output logic       frame_start,
    output logic [3:0] ftsd_ctl,
    output logic [3:0] ftsd_in
);
    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    localparam logic [DIV_W-1:0] CNT_MAX   = '1;
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][3:0]  sh_q, sh_d;
    logic [3:0]       ctl_q, ctl_d;
    logic [3:0]       dat_q, dat_d;
    logic             ack_q, ack_d;
    logic             fs_q, fs_d;
    logic             tick;
    logic             boundary;

    assign tick     = (cnt_q == CNT_MAX);
    assign boundary = tick && (idx_q == 2'd3);

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = tick ? idx_q + 2'd1 : idx_q;
        state_d = state_q;
        ctl_d   = 4'b1111;
        dat_d   = 4'b0000;
        fs_d    = boundary;
        ack_d   = boundary && upd_req;
        sh_d    = ack_d ? {in3, in2, in1, in0} : sh_q;

        if (state_q == ST_BLANK && cnt_q == BLANK_END)
            state_d = ST_SHOW;
        // A tick always restarts the period, overriding the blank-end exit.
        if (tick)
            state_d = (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;

        if (state_q == ST_SHOW && digit_en[idx_q]) begin
            ctl_d = ~(4'b1000 >> idx_q);
            dat_d = sh_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            sh_q    <= '0;
            ctl_q   <= 4'b1111;
            dat_q   <= 4'b0000;
            ack_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            ctl_q   <= ctl_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            fs_q    <= fs_d;
        end
    end

    assign ftsd_ctl    = ctl_q;
    assign ftsd_in     = dat_q;
    assign upd_ack     = ack_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_ftsd_scan_sched.sv
// Bench for ftsd_scan_sched: blanked (DIV_W=3, BLANK_CYC=2) and unblanked (DIV_W=2, BLANK_CYC=0) instances.
module tb_ftsd_scan_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ins;
    logic [3:0]  digit_en;
    logic        upd_req;
    logic        ack_a, fs_a, ack_b, fs_b;
    logic [3:0]  ctl_a, dat_a, ctl_b, dat_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ftsd_scan_sched #(.DIV_W(3), .BLANK_CYC(2)) dut_a (
        .clk(clk), .rst(rst),
        .in0(ins[3:0]), .in1(ins[7:4]), .in2(ins[11:8]), .in3(ins[15:12]),
        .digit_en(digit_en), .upd_req(upd_req),
        .upd_ack(ack_a), .frame_start(fs_a), .ftsd_ctl(ctl_a), .ftsd_in(dat_a)
    );

    ftsd_scan_sched #(.DIV_W(2), .BLANK_CYC(0)) dut_b (
        .clk(clk), .rst(rst),
        .in0(ins[3:0]), .in1(ins[7:4]), .in2(ins[11:8]), .in3(ins[15:12]),
        .digit_en(digit_en), .upd_req(upd_req),
        .upd_ack(ack_b), .frame_start(fs_b), .ftsd_ctl(ctl_b), .ftsd_in(dat_b)
    );

    // Reference model: the scan position follows purely from the number of edges since reset.
    int         n_m   [2];
    logic [3:0] sh_m  [2][4];
    logic [3:0] e_ctl [2];
    logic [3:0] e_dat [2];
    logic       e_ack [2];
    logic       e_fs  [2];

    task automatic model_edge(input int k, input int dw, input int bc);
        int         per, cnt, idx;
        bit         blank;
        logic [3:0] one;
        per = 1 << dw;
        if (rst) begin
            n_m[k] = 0;
            for (int d = 0; d < 4; d++) sh_m[k][d] = 4'h0;
            e_ctl[k] = 4'b1111; e_dat[k] = 4'h0; e_ack[k] = 1'b0; e_fs[k] = 1'b0;
            return;
        end
        n_m[k]++;
        cnt   = (n_m[k] - 1) % per;
        idx   = ((n_m[k] - 1) / per) % 4;
        blank = (n_m[k] == 1) || (bc > 0 && cnt <= bc);
        one   = 4'b1000;
        if (blank || !digit_en[idx]) begin
            e_ctl[k] = 4'b1111; e_dat[k] = 4'h0;
        end else begin
            e_ctl[k] = ~(one >> idx); e_dat[k] = sh_m[k][idx];
        end
        e_fs[k]  = (n_m[k] % (4 * per)) == 0;
        e_ack[k] = e_fs[k] && upd_req;
        if (e_ack[k])
            for (int d = 0; d < 4; d++) sh_m[k][d] = ins[4*d +: 4];
    endtask

    task automatic check_out(input string nm,
                             input logic [3:0] c, input logic [3:0] d, input logic a, input logic f,
                             input logic [3:0] ec, input logic [3:0] ed, input logic ea, input logic ef);
        checks++;
        if ({c, d, a, f} !== {ec, ed, ea, ef}) begin
            errors++;
            $display("FAIL %s: got ctl=%b dat=%h ack=%b fs=%b, want ctl=%b dat=%h ack=%b fs=%b",
                     nm, c, d, a, f, ec, ed, ea, ef);
        end
    endtask

    task automatic cyc();
        model_edge(0, 3, 2);
        model_edge(1, 2, 0);
        @(posedge clk);
        @(negedge clk);
        check_out($sformatf("model_a n=%0d", n_m[0]), ctl_a, dat_a, ack_a, fs_a,
                  e_ctl[0], e_dat[0], e_ack[0], e_fs[0]);
        check_out($sformatf("model_b n=%0d", n_m[1]), ctl_b, dat_b, ack_b, fs_b,
                  e_ctl[1], e_dat[1], e_ack[1], e_fs[1]);
    endtask

    typedef struct {
        int          ncyc;
        logic        rst;
        logic        req;
        logic [3:0]  en;
        logic [15:0] ins;
        logic [3:0]  ctl;
        logic [3:0]  dat;
        logic        ack;
        logic        fs;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int nc, input logic r, input logic q, input logic [3:0] en,
                       input logic [15:0] iv, input logic [3:0] c, input logic [3:0] d,
                       input logic a, input logic f);
        vec_t v;
        v.ncyc = nc; v.rst = r; v.req = q; v.en = en; v.ins = iv;
        v.ctl = c; v.dat = d; v.ack = a; v.fs = f;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1; upd_req = 1'b0; digit_en = 4'hF; ins = 16'h0;

        // Directed vectors for the DIV_W=3 / BLANK_CYC=2 instance; checked after the last cycle of each run.
        add( 3, 1, 0, 4'hF, 16'h0000, 4'b1111, 4'h0, 0, 0);
        add( 1, 0, 0, 4'hF, 16'h0000, 4'b1111, 4'h0, 0, 0);
        add( 2, 0, 0, 4'hF, 16'h0000, 4'b1111, 4'h0, 0, 0);
        add( 1, 0, 0, 4'hF, 16'h0000, 4'b0111, 4'h0, 0, 0);
        add( 4, 0, 1, 4'hF, 16'h4321, 4'b0111, 4'h0, 0, 0);
        add( 1, 0, 1, 4'hF, 16'h4321, 4'b1111, 4'h0, 0, 0);
        add( 2, 0, 1, 4'hF, 16'h4321, 4'b1111, 4'h0, 0, 0);
        add( 1, 0, 1, 4'hF, 16'h4321, 4'b1011, 4'h0, 0, 0);
        add(20, 0, 1, 4'hF, 16'h4321, 4'b1110, 4'h0, 1, 1);
        add( 4, 0, 0, 4'hF, 16'h4321, 4'b0111, 4'h1, 0, 0);
        add( 8, 0, 0, 4'hF, 16'h4721, 4'b1011, 4'h2, 0, 0);
        add( 8, 0, 0, 4'hF, 16'h9999, 4'b1101, 4'h3, 0, 0);
        add( 8, 0, 0, 4'hF, 16'h9999, 4'b1110, 4'h4, 0, 0);
        add( 4, 0, 0, 4'hF, 16'h9999, 4'b1110, 4'h4, 0, 1);
        add( 4, 0, 0, 4'hA, 16'h9999, 4'b1111, 4'h0, 0, 0);
        add( 8, 0, 0, 4'hA, 16'h9999, 4'b1011, 4'h2, 0, 0);
        add( 8, 0, 0, 4'hA, 16'h9999, 4'b1111, 4'h0, 0, 0);
        add( 8, 0, 0, 4'hA, 16'h9999, 4'b1110, 4'h4, 0, 0);
        add( 1, 0, 0, 4'h2, 16'h9999, 4'b1111, 4'h0, 0, 0);
        add( 1, 1, 1, 4'hF, 16'h4321, 4'b1111, 4'h0, 0, 0);
        add(31, 0, 1, 4'hF, 16'h4321, 4'b1110, 4'h0, 0, 0);
        add( 1, 0, 1, 4'hF, 16'h4321, 4'b1110, 4'h0, 1, 1);
        add( 4, 0, 1, 4'hF, 16'h4321, 4'b0111, 4'h1, 0, 0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; upd_req = tbl[i].req; digit_en = tbl[i].en; ins = tbl[i].ins;
            for (int c = 0; c < tbl[i].ncyc; c++) cyc();
            check_out($sformatf("vec%0d", i), ctl_a, dat_a, ack_a, fs_a,
                      tbl[i].ctl, tbl[i].dat, tbl[i].ack, tbl[i].fs);
        end

        // Random traffic against the model, including occasional mid-frame resets.
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            upd_req  = ($urandom_range(0, 1) == 1);
            digit_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            if ($urandom_range(0, 3) == 0) ins = 16'($urandom);
            cyc();
        end

        // Zero blanking: after the first post-reset cycle every cycle selects exactly one digit.
        rst = 1'b1; upd_req = 1'b0; digit_en = 4'hF;
        cyc(); cyc();
        rst = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            logic [3:0] want;
            logic [3:0] one;
            one  = 4'b1000;
            want = (n == 1) ? 4'b1111 : ~(one >> (((n - 1) / 4) % 4));
            cyc();
            check_out($sformatf("noblank n=%0d", n), ctl_b, dat_b, ack_b, fs_b,
                      want, 4'h0, 1'b0, (n % 16) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
